lfsr_solver_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `polynomial_finder` instance between three requesters, typically three `pulse_identifier` instances serving different sensor groups. Each requester presents two decoded words and their timestamps. The block grants one job at a time, latches its operands, and drives the finder through its enable/ready handshake. It returns the polynomial and iteration count with a one-cycle done pulse, and aborts jobs that exceed a timeout.

---
 rtl/lfsr_solver_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_lfsr_solver_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_solver_arbiter.sv
// Round-robin arbiter that shares one polynomial_finder between three requesters,
// latching each job's operands and sequencing the finder's enable/ready handshake.
`timescale 1ns/1ps

package lfsr_solver_arbiter_pkg;
  localparam int unsigned TS_W   = 24;
  localparam int unsigned DATA_W = 17;

  typedef struct packed {
    logic [TS_W-1:0]   ts_a;
    logic [TS_W-1:0]   ts_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
  } job_t;
endpackage

module lfsr_solver_arbiter
  import lfsr_solver_arbiter_pkg::*;
#(
  parameter int unsigned timeout_ticks = 50000
) (
  input  logic              clk_96MHz,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [TS_W-1:0]   ts_a_0,
  input  logic [TS_W-1:0]   ts_a_1,
  input  logic [TS_W-1:0]   ts_a_2,
  input  logic [TS_W-1:0]   ts_b_0,
  input  logic [TS_W-1:0]   ts_b_1,
  input  logic [TS_W-1:0]   ts_b_2,
  input  logic [DATA_W-1:0] data_a_0,
  input  logic [DATA_W-1:0] data_a_1,
  input  logic [DATA_W-1:0] data_a_2,
  input  logic [DATA_W-1:0] data_b_0,
  input  logic [DATA_W-1:0] data_b_1,
  input  logic [DATA_W-1:0] data_b_2,
  output logic [2:0]        grant,
  output logic [2:0]        done,
  output logic [DATA_W-1:0] result_polynomial,
  output logic [DATA_W-1:0] result_iteration,
  output logic              result_error,
  output logic [7:0]        error_count,
  output logic              finder_enable,
  output logic [TS_W-1:0]   finder_ts_last_data,
  output logic [TS_W-1:0]   finder_ts_last_data1,
  output logic [DATA_W-1:0] finder_decoded_data,
  output logic [DATA_W-1:0] finder_decoded_data1,
  input  logic              finder_ready,
  input  logic [DATA_W-1:0] finder_polynomial,
  input  logic [DATA_W-1:0] finder_iteration
);

  localparam int unsigned N_REQ = 3;
  localparam int unsigned CNT_W = 17;
  localparam int unsigned ERR_W = 8;

  typedef enum logic [2:0] {IDLE, LAUNCH, BUSY, FAIL, RELEASE} state_t;

  state_t             state, state_n;
  logic [1:0]         ptr, ptr_n;
  logic [1:0]         win, rr_idx;
  logic               win_vld;
  logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
  logic               tmo_hit;
  job_t               job, job_n, job_sel;
  logic [N_REQ-1:0]   grant_n, done_n;
  logic               enable_n, err_n;
  logic [DATA_W-1:0]  poly_n, iter_n;
  logic [ERR_W-1:0]   ecnt_n, ecnt_sat;

  assign finder_ts_last_data  = job.ts_a;
  assign finder_ts_last_data1 = job.ts_b;
  assign finder_decoded_data  = job.data_a;
  assign finder_decoded_data1 = job.data_b;

  assign tmo_hit  = (32'(cnt) + 32'd1) >= timeout_ticks;
  assign cnt_inc  = (32'(cnt) < timeout_ticks) ? cnt + CNT_W'(1) : cnt;
  assign ecnt_sat = (error_count == '1) ? error_count : error_count + ERR_W'(1);

  // Scan ptr+3 down to ptr+1 so the highest-priority requester is assigned last.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    rr_idx  = ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_idx = 2'((32'(ptr) + 32'(k)) % N_REQ);
      if (req[rr_idx]) begin
        win     = rr_idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    case (win)
      2'd1:    job_sel = '{ts_a: ts_a_1, ts_b: ts_b_1, data_a: data_a_1, data_b: data_b_1};
      2'd2:    job_sel = '{ts_a: ts_a_2, ts_b: ts_b_2, data_a: data_a_2, data_b: data_b_2};
      default: job_sel = '{ts_a: ts_a_0, ts_b: ts_b_0, data_a: data_a_0, data_b: data_b_0};
    endcase
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    cnt_n    = cnt;
    job_n    = job;
    grant_n  = grant;
    done_n   = '0;
    enable_n = finder_enable;
    poly_n   = result_polynomial;
    iter_n   = result_iteration;
    err_n    = result_error;
    ecnt_n   = error_count;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_n  = LAUNCH;
          grant_n  = N_REQ'(1) << win;
          ptr_n    = win;
          job_n    = job_sel;
          cnt_n    = '0;
          enable_n = 1'b1;
        end
      end
      LAUNCH: begin
        enable_n = 1'b1;
        cnt_n    = cnt_inc;
        if (!finder_ready)  state_n = BUSY;
        else if (tmo_hit)   state_n = FAIL;
      end
      BUSY: begin
        enable_n = 1'b1;
        cnt_n    = cnt_inc;
        if (finder_ready) begin
          done_n  = grant;
          state_n = RELEASE;
          if (finder_polynomial == '0) begin
            err_n  = 1'b1;
            poly_n = '0;
            iter_n = '0;
            ecnt_n = ecnt_sat;
          end else begin
            err_n  = 1'b0;
            poly_n = finder_polynomial;
            iter_n = finder_iteration;
          end
        end else if (tmo_hit) begin
          state_n = FAIL;
        end
      end
      FAIL: begin
        done_n  = grant;
        err_n   = 1'b1;
        poly_n  = '0;
        iter_n  = '0;
        ecnt_n  = ecnt_sat;
        state_n = RELEASE;
      end
      RELEASE: begin
        enable_n = 1'b0;
        grant_n  = '0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state             <= IDLE;
      ptr               <= 2'd2;
      cnt               <= '0;
      job               <= '0;
      grant             <= '0;
      done              <= '0;
      finder_enable     <= 1'b0;
      result_polynomial <= '0;
      result_iteration  <= '0;
      result_error      <= 1'b0;
      error_count       <= '0;
    end else begin
      state             <= state_n;
      ptr               <= ptr_n;
      cnt               <= cnt_n;
      job               <= job_n;
      grant             <= grant_n;
      done              <= done_n;
      finder_enable     <= enable_n;
      result_polynomial <= poly_n;
      result_iteration  <= iter_n;
      result_error      <= err_n;
      error_count       <= ecnt_n;
    end
  end

endmodule

// File: tb/tb_lfsr_solver_arbiter.sv
// Randomized bench for lfsr_solver_arbiter: a scripted finder model plus a job-level
// reference (round-robin pick, latency from ready timing, error bookkeeping).
`timescale 1ns/1ps

module tb_lfsr_solver_arbiter;

  localparam int T = 100;

  logic        clk_96MHz = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] ts_a [3];
  logic [23:0] ts_b [3];
  logic [16:0] data_a [3];
  logic [16:0] data_b [3];
  logic [2:0]  grant, done;
  logic [16:0] result_polynomial, result_iteration;
  logic        result_error;
  logic [7:0]  error_count;
  logic        finder_enable;
  logic [23:0] finder_ts_last_data, finder_ts_last_data1;
  logic [16:0] finder_decoded_data, finder_decoded_data1;
  logic        finder_ready;
  logic [16:0] fpoly, fiter;

  int fa, fb, fk;
  bit en_prev;
  int vectors = 0;
  int miscompares = 0;
  int ptr_m, errs_m, last_win;
  logic [16:0] exp_poly, exp_iter;
  logic        exp_err;

  lfsr_solver_arbiter #(.timeout_ticks(T)) dut (
    .clk_96MHz(clk_96MHz), .reset(reset), .req(req),
    .ts_a_0(ts_a[0]), .ts_a_1(ts_a[1]), .ts_a_2(ts_a[2]),
    .ts_b_0(ts_b[0]), .ts_b_1(ts_b[1]), .ts_b_2(ts_b[2]),
    .data_a_0(data_a[0]), .data_a_1(data_a[1]), .data_a_2(data_a[2]),
    .data_b_0(data_b[0]), .data_b_1(data_b[1]), .data_b_2(data_b[2]),
    .grant(grant), .done(done),
    .result_polynomial(result_polynomial), .result_iteration(result_iteration),
    .result_error(result_error), .error_count(error_count),
    .finder_enable(finder_enable),
    .finder_ts_last_data(finder_ts_last_data), .finder_ts_last_data1(finder_ts_last_data1),
    .finder_decoded_data(finder_decoded_data), .finder_decoded_data1(finder_decoded_data1),
    .finder_ready(finder_ready), .finder_polynomial(fpoly), .finder_iteration(fiter)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  // Finder model: ready is low for cycles [fa, fb) counted from the first enabled cycle.
  initial begin
    finder_ready = 1'b1;
    fk = 0;
    en_prev = 1'b0;
    forever begin
      @(posedge clk_96MHz);
      #1;
      if (finder_enable) fk = en_prev ? fk + 1 : 0;
      en_prev = finder_enable;
      finder_ready = !(finder_enable && fk >= fa && fk < fb);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_96MHz);
    #1;
  endtask

  function automatic int rr_pick(input logic [2:0] r, input int p);
    for (int k = 1; k <= 3; k++) begin
      if (r[(p + k) % 3]) return (p + k) % 3;
    end
    return 0;
  endfunction

  task automatic randomize_operands();
    for (int i = 0; i < 3; i++) begin
      ts_a[i]   = 24'($urandom);
      ts_b[i]   = 24'($urandom);
      data_a[i] = 17'($urandom);
      data_b[i] = 17'($urandom);
    end
  endtask

  // One complete job: grant, latency, results, release cycle; winner drops req afterwards.
  task automatic run_job(input logic [2:0] add, input int a, input int b,
                         input logic [16:0] poly, input logic [16:0] iter, input bit mutate);
    int w, lat, k;
    bit err;
    logic [23:0] eta, etb;
    logic [16:0] eda, edb;
    req = req | add;
    fa = a; fb = b; fpoly = poly; fiter = iter;
    w = rr_pick(req, ptr_m);
    eta = ts_a[w]; etb = ts_b[w]; eda = data_a[w]; edb = data_b[w];
    step();
    last_win = w;
    check("grant", 32'(grant), 32'(1 << w));
    check("enable_on", 32'(finder_enable), 32'd1);
    check("op_ts_a", 32'(finder_ts_last_data), 32'(eta));
    check("op_ts_b", 32'(finder_ts_last_data1), 32'(etb));
    check("op_data_a", 32'(finder_decoded_data), 32'(eda));
    check("op_data_b", 32'(finder_decoded_data1), 32'(edb));
    ptr_m = w;
    err = (b > T - 1) || (poly == 17'd0);
    lat = (b <= T - 1) ? b + 1 : T + 1;
    k = 0;
    while (done == 3'b000 && k < T + 20) begin
      if (mutate) begin
        ts_a[w]   = 24'($urandom);
        data_a[w] = 17'($urandom);
      end
      step();
      k++;
    end
    if (err) begin
      exp_poly = 17'd0; exp_iter = 17'd0; exp_err = 1'b1;
      errs_m = (errs_m < 255) ? errs_m + 1 : 255;
    end else begin
      exp_poly = poly; exp_iter = iter; exp_err = 1'b0;
    end
    check("latency", 32'(k), 32'(lat));
    check("done", 32'(done), 32'(1 << w));
    check("result_poly", 32'(result_polynomial), 32'(exp_poly));
    check("result_iter", 32'(result_iteration), 32'(exp_iter));
    check("result_error", 32'(result_error), 32'(exp_err));
    check("error_count", 32'(error_count), 32'(errs_m));
    check("op_held", 32'(finder_decoded_data), 32'(eda));
    step();
    check("done_1cyc", 32'(done), 32'd0);
    check("release_grant", 32'(grant), 32'd0);
    check("release_enable", 32'(finder_enable), 32'd0);
    check("result_held", 32'(result_polynomial), 32'(exp_poly));
    req[w] = 1'b0;
  endtask

  initial begin
    int a, b;
    logic [2:0] add;
    logic [16:0] poly;
    reset = 1'b1;
    req = 3'b000;
    fa = 1; fb = 2; fpoly = 17'd0; fiter = 17'd0;
    ptr_m = 2; errs_m = 0; last_win = 0;
    exp_poly = 17'd0; exp_iter = 17'd0; exp_err = 1'b0;
    randomize_operands();
    repeat (3) step();
    reset = 1'b0;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_enable", 32'(finder_enable), 32'd0);
    check("rst_poly", 32'(result_polynomial), 32'd0);
    check("rst_ecount", 32'(error_count), 32'd0);
    check("rst_operand", 32'(finder_ts_last_data), 32'd0);
    step();

    run_job(3'b001, 1, 5, 17'h1D258, 17'd42, 1'b0);

    // Contention: everyone keeps requesting; pointer now at 0 so order is 1,2,0,1,2,0.
    for (int i = 0; i < 6; i++) begin
      randomize_operands();
      run_job(3'b111, 1, 3, 17'($urandom_range(1, 131071)), 17'($urandom), i == 0);
      check("rr_order", 32'(last_win), 32'((i + 1) % 3));
    end

    // Timeout boundaries and a finder that never drops ready.
    run_job(3'b001, 1, T - 1, 17'h00ABC, 17'd7, 1'b0);
    run_job(3'b010, 1, T, 17'h00ABC, 17'd7, 1'b0);
    run_job(3'b100, 100000, 100000, 17'h00ABC, 17'd7, 1'b0);
    run_job(3'b001, 2, 4, 17'd0, 17'd9, 1'b0);

    for (int i = 0; i < 40; i++) begin
      randomize_operands();
      add = 3'($urandom_range(0, 7));
      if ((req | add) == 3'b000) add = 3'b001;
      a = $urandom_range(1, 5);
      b = (i % 8 == 7) ? $urandom_range(T - 3, T + 5) : a + $urandom_range(1, 8);
      poly = ($urandom_range(0, 5) == 0) ? 17'd0 : 17'($urandom_range(1, 131071));
      run_job(add, a, b, poly, 17'($urandom), i % 5 == 0);
    end

    for (int i = 0; i < 300; i++) run_job(3'b111, 1, 2, 17'd0, 17'd1, 1'b0);

    // Reset in the middle of a busy job.
    req = req | 3'b100;
    fa = 1; fb = 60; fpoly = 17'h12345; fiter = 17'd3;
    step();
    check("pre_rst_grant", 32'(grant != 3'b000), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("busy_no_done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_enable", 32'(finder_enable), 32'd0);
    check("mid_rst_poly", 32'(result_polynomial), 32'd0);
    check("mid_rst_iter", 32'(result_iteration), 32'd0);
    check("mid_rst_error", 32'(result_error), 32'd0);
    check("mid_rst_ecount", 32'(error_count), 32'd0);
    check("mid_rst_operand", 32'(finder_decoded_data), 32'd0);
    ptr_m = 2; errs_m = 0;
    req = 3'b110;
    randomize_operands();
    run_job(3'b000, 1, 3, 17'h0F0F0, 17'd5, 1'b0);
    check("post_rst_pick", 32'(last_win), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
